// File: rtl/ddr4_axi_fifo_rd_framer_pkg.sv
// Shared types and constants for the DDR4 AXI read-data framing path.
package ddr4_axi_fifo_rd_framer_pkg;

    // Number of entries in the output skid buffer.
    localparam int SKID_DEPTH = 2;

    // Width of a counter that must hold 0..SKID_DEPTH.
    localparam int SKID_OCC_W = $clog2(SKID_DEPTH + 1);

    // Burst framer control states.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ddr4_axi_skid2.sv
// Generic 2-entry valid/ready buffer. Upstream ready is decoded from the
// registered occupancy only, so it never combinationally depends on the
// downstream ready. Entry 0 is the head and drives the output directly.
module ddr4_axi_skid2
    import ddr4_axi_fifo_rd_framer_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    input  logic [W-1:0] s_data_i,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o
);

    localparam logic [SKID_OCC_W-1:0] OCC_FULL = SKID_OCC_W'(SKID_DEPTH);

    logic [SKID_OCC_W-1:0] occ_q, occ_d;
    logic [W-1:0]          ent0_q, ent0_d;
    logic [W-1:0]          ent1_q, ent1_d;
    logic                  push;
    logic                  pop;

    assign s_ready_o = (occ_q != OCC_FULL);
    assign m_valid_o = (occ_q != '0);
    assign m_data_o  = ent0_q;

    assign push = s_valid_i & s_ready_o;
    assign pop  = m_valid_o & m_ready_i;

    // Next occupancy and entry contents from the push/pop combination.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        occ_d  = occ_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case ({push, pop})
            2'b10: begin
                occ_d = occ_q + SKID_OCC_W'(1);
                if (occ_q == '0) begin
                    ent0_d = s_data_i;
                end else begin
                    ent1_d = s_data_i;
                end
            end
            2'b01: begin
                occ_d  = occ_q - SKID_OCC_W'(1);
                ent0_d = ent1_q;
            end
            2'b11: begin
                // Only reachable with one entry held: head leaves, new beat takes its place.
                ent0_d = s_data_i;
            end
            default: begin
            end
        endcase
    end

    // Occupancy and entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            // NOTE: the data entries are cleared as well so the output reads zero after reset.
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            occ_q  <= occ_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

endmodule

// File: rtl/ddr4_axi_fifo_rd_framer.sv
// Read-side consumer for a show-ahead FIFO. Pops one burst of beats per
// accepted command, tags the final beat with last and presents the beats
// on a valid/ready master port through a 2-entry skid. The FIFO pop strobe
// depends only on flops and the FIFO empty flag.
module ddr4_axi_fifo_rd_framer
    import ddr4_axi_fifo_rd_framer_pkg::*;
#(
    parameter int C_WIDTH     = 8,
    parameter int C_LEN_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [C_LEN_WIDTH-1:0] cmd_len,
    input  logic [C_WIDTH-1:0]     fifo_dout,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [C_WIDTH-1:0]     m_data,
    output logic                   m_last,
    output logic                   busy
);

    typedef struct packed {
        logic [C_WIDTH-1:0] data;
        logic               last;
    } skid_entry_t;

    localparam int ENTRY_W = $bits(skid_entry_t);

    rd_state_e              state_q, state_d;
    logic [C_LEN_WIDTH-1:0] rem_q, rem_d;
    logic                   pop;
    logic                   last_beat;
    logic                   skid_ready;
    skid_entry_t            s_entry;
    skid_entry_t            m_entry;
    logic [ENTRY_W-1:0]     skid_in;
    logic [ENTRY_W-1:0]     skid_out;

    // Command handshake, pop decision and remaining-beat count.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        cmd_ready = 1'b0;
        pop       = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) begin
                    rem_d   = cmd_len;
                    state_d = BURST;
                end
            end
            BURST: begin
                pop = !fifo_empty && skid_ready && !rst;
                if (pop) begin
                    if (rem_q == '0) begin
                        // rem parks at zero here rather than wrapping.
                        last_beat = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        rem_d = rem_q - C_LEN_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and remaining-beat registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign fifo_rd_en = pop;
    assign s_entry    = '{data: fifo_dout, last: last_beat};
    assign skid_in    = s_entry;
    assign m_entry    = skid_out;
    assign m_data     = m_entry.data;
    assign m_last     = m_entry.last;
    assign busy       = (state_q == BURST) || m_valid;

    ddr4_axi_skid2 #(
        .W (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_valid_i (pop),
        .s_ready_o (skid_ready),
        .s_data_i  (skid_in),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (skid_out)
    );

endmodule

// File: doc/ddr4_axi_fifo_rd_framer.md
Name: ddr4_axi_fifo_rd_framer

Overview:
- Read-side consumer for the controller's shallow show-ahead AXI FIFOs (data valid on dout whenever empty=0).
- Pops beats under a per-burst command and tags the final beat with last.
- Presents beats on a valid/ready master port through a 2-entry output skid.
- rd_en depends only on flops and the FIFO empty flag, never on m_ready.
- Used on the read-data return path between the FIFO and the AXI R channel.

Parameters:
- C_WIDTH, 8, data width; must equal the attached FIFO's width.
- C_LEN_WIDTH, 8, burst length field width; AXI encoding, beats = len+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  command accepted; high only in IDLE and only while rst=0.
- cmd_len  in  C_LEN_WIDTH  beats-1 of the burst.
- fifo_dout  in  C_WIDTH  FIFO head data (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe to the FIFO.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  C_WIDTH  output beat data.
- m_last  out  1  final beat of the burst.
- busy  out  1  state=BURST or skid occupancy != 0.

Behaviour:
- State machine: IDLE, BURST.
  - IDLE: cmd_ready=1. On cmd_valid, load rem=cmd_len and go to BURST next cycle.
  - BURST: cmd_ready=0. On each pop, rem decrements. The pop with rem==0 is tagged last and the next state is IDLE.
- Pop rule: fifo_rd_en = (state==BURST) & !fifo_empty & (occ != 2). occ is the registered skid occupancy (0..2).
- Skid: two entries {data,last}; entry 0 is the head.
  - m_valid = (occ != 0). m_data/m_last come from entry 0, straight from flops.
  - Pop & no accept: occ+1. Accept (m_valid & m_ready) & no pop: occ-1, entry1 shifts to entry0. Both: occ unchanged.
  - Order is strictly preserved.
- Latency:
  - fifo_dout sampled on the pop edge (cycle t); beat visible on m_* at t+1.
  - A command accepted at cycle t allows the first pop at t+1.
- Throughput: 1 beat/cycle sustained with m_ready held high (occ stays 1).
- Back-to-back bursts:
  - Return to IDLE costs one bubble cycle for the command handshake.
  - Skid contents from the previous burst continue draining meanwhile.
- Boundaries:
  - fifo_empty=1 in BURST: no pop, rem holds, state holds. No underflow is possible.
  - occ==2: no pop even if m_ready=1 that cycle (one-cycle bubble; accepted for timing).
  - cmd_len=0: single beat, m_last=1 on it.
  - cmd_len=all-ones: 2^C_LEN_WIDTH beats. rem must not wrap before the last tag.
  - cmd_valid while in BURST: ignored, cmd_ready=0.
  - m_ready while m_valid=0: no effect.
- Reset, including mid-burst:
  - State=IDLE, rem=0, occ=0, skid entries cleared to 0.
  - Outputs: m_valid=0, m_last=0, m_data=0, fifo_rd_en=0, busy=0, cmd_ready=0 while rst=1.
  - In-flight skid beats are discarded. The FIFO is reset by the same rst by system convention.

Decomposition:
- Shared package (ddr4 AXI package):
  - State enum typedef {IDLE, BURST}.
  - Skid entry struct {data, last} (parameterised by width via the module).
  - Localparam SKID_DEPTH=2.
- One natural sub-module: ddr4_axi_skid2.
  - Generic 2-entry valid/ready buffer with registered-only upstream ready.
  - Reusable on the AW/AR paths.

Test Plan:
- Single beat: FIFO preloaded with 0xA5, cmd_len=0, m_ready=1 -> one pop; m_valid 2 cycles after command accept; m_data=0xA5, m_last=1; cmd_ready high again the cycle after the pop.
- Streaming: FIFO holds 0x00..0x07, cmd_len=7, m_ready=1 -> 8 consecutive m_valid cycles with data 0x00..0x07; m_last only on 0x07; fifo_rd_en high exactly 8 cycles.
- Backpressure: cmd_len=3, m_ready=0 for 5 cycles then 1 -> occ reaches 2 and fifo_rd_en drops; no data lost or duplicated; output order 0,1,2,3; m_last on the 4th beat.
- FIFO starvation: cmd_len=3, FIFO empty for cycles 2-5 mid-burst -> no pops while empty, rem holds, state stays BURST, m_valid deasserts after draining; burst completes when data arrives.
- Max length + back-to-back: cmd_len=255, then cmd_len=1 -> 256 beats with a single last, then 2 beats with last on the 2nd; cmd_valid held during BURST is not accepted early.
- Reset mid-burst: rst for 1 cycle after 3 of 8 beats with occ=2 -> next cycle m_valid=0, busy=0, fifo_rd_en=0; cmd_ready=1 after rst deasserts; a new cmd_len=0 burst completes normally.
